// File: rtl/audio_pkg.sv
// Shared constants and types for the speaker tone path and its SPI DAC serializer.
package audio_pkg;
    localparam int          DAC_FRAME_BITS = 16;
    localparam logic [11:0] DAC_MIDSCALE   = 12'd2048;
    localparam logic [3:0]  MAX_LEVEL      = 4'd9;
    localparam logic [1:0]  DAC_PD_NORMAL  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } tx_state_t;

    function automatic logic [3:0] clamp_level(input logic [3:0] level);
        return (level > MAX_LEVEL) ? MAX_LEVEL : level;
    endfunction
endpackage

// File: rtl/dac_spi_tx.sv
// 16-bit SPI frame serializer for a DAC121S101-style converter (sync low, SCLK idles high).
// state | meaning
// IDLE  | sync/sclk high, waiting for start
// SHIFT | sync low, 16 bits MSB first, din updated at start of each bit
// DONE  | one idle-level cycle before accepting the next frame
module dac_spi_tx
    import audio_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DAC_FRAME_BITS-1:0] word,
    output logic                      dac_sync,
    output logic                      dac_sclk,
    output logic                      dac_din,
    output logic                      busy
);
    localparam int          PH_W     = $clog2(2 * SCLK_DIV);
    localparam logic [PH_W-1:0] PH_FALL = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DAC_FRAME_BITS - 1);

    tx_state_t                 state_q, state_n;
    logic [DAC_FRAME_BITS-1:0] shift_q, shift_n;
    logic [PH_W-1:0]           phase_q, phase_n;
    logic [3:0]                bit_q, bit_n;
    logic                      sync_q, sync_n;
    logic                      sclk_q, sclk_n;
    logic                      din_q, din_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            phase_q <= phase_n;
            bit_q   <= bit_n;
            sync_q  <= sync_n;
            sclk_q  <= sclk_n;
            din_q   <= din_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        sync_n  = sync_q;
        sclk_n  = sclk_q;
        din_n   = din_q;
        unique case (state_q)
            IDLE: begin
                sync_n = 1'b1;
                sclk_n = 1'b1;
                din_n  = 1'b0;
                if (start) begin
                    state_n = SHIFT;
                    sync_n  = 1'b0;
                    din_n   = word[DAC_FRAME_BITS-1];
                    shift_n = {word[DAC_FRAME_BITS-2:0], 1'b0};
                    phase_n = '0;
                    bit_n   = '0;
                end
            end
            SHIFT: begin
                phase_n = phase_q + 1'b1;
                if (phase_q == PH_FALL) begin
                    sclk_n = 1'b0;
                end
                // Bit boundary: sclk rises and din moves together, well before the next falling edge.
                if (phase_q == PH_LAST) begin
                    phase_n = '0;
                    sclk_n  = 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_n = DONE;
                        sync_n  = 1'b1;
                        din_n   = 1'b0;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        din_n   = shift_q[DAC_FRAME_BITS-1];
                        shift_n = {shift_q[DAC_FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dac_sync = sync_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;
    assign busy     = (state_q == SHIFT);
endmodule

// File: rtl/audio_output_task.sv
// Level-scaled square tone generator streaming one 12-bit sample per sample tick to an SPI DAC.
module audio_output_task
    import audio_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SAMPLE_HZ  = 20_000,
    parameter int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ,
    parameter int SCLK_DIV   = 2,
    parameter int TONE_INC   = 3277,
    parameter int AMP_STEP   = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] audio_output_number,
    output logic       dac_sync,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy,
    output logic       overrun
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]          tick_cnt;
    logic                      tick;
    logic [15:0]               acc;
    logic [3:0]                level;
    logic [10:0]               amp;
    logic [11:0]               sample;
    logic [DAC_FRAME_BITS-1:0] word;
    logic                      start;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign level = clamp_level(audio_output_number);
    assign amp   = 11'(level) * 11'(AMP_STEP);

    // Amplitude never exceeds 1800, so midscale +/- amp stays inside 12 bits.
    always_comb begin
        sample = DAC_MIDSCALE;
        if (enable) begin
            sample = acc[15] ? (DAC_MIDSCALE + 12'(amp)) : (DAC_MIDSCALE - 12'(amp));
        end
    end

    assign word  = {2'b00, DAC_PD_NORMAL, sample};
    assign start = tick & ~busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            overrun <= 1'b0;
        end else if (tick) begin
            acc <= enable ? (acc + 16'(TONE_INC)) : '0;
            if (busy) begin
                overrun <= 1'b1;
            end
        end
    end

    dac_spi_tx #(
        .SCLK_DIV(SCLK_DIV)
    ) u_tx (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .word    (word),
        .dac_sync(dac_sync),
        .dac_sclk(dac_sclk),
        .dac_din (dac_din),
        .busy    (busy)
    );
endmodule

// File: tb/tb_audio_output_task.sv
// Directed bench: default-rate instance for timing/reset, fast legal instance for waveform table, too-fast instance for overrun.
module tb_audio_output_task;
    logic       clock = 1'b0;
    logic [2:0] rst;
    logic [2:0] en;
    logic [3:0] lvl [3];
    logic [2:0] sync_w, sclk_w, din_w, busy_w, ovr_w;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    audio_output_task u_dut_a (
        .clock(clock), .reset(rst[0]), .enable(en[0]), .audio_output_number(lvl[0]),
        .dac_sync(sync_w[0]), .dac_sclk(sclk_w[0]), .dac_din(din_w[0]),
        .busy(busy_w[0]), .overrun(ovr_w[0])
    );

    audio_output_task #(.SAMPLE_DIV(100)) u_dut_b (
        .clock(clock), .reset(rst[1]), .enable(en[1]), .audio_output_number(lvl[1]),
        .dac_sync(sync_w[1]), .dac_sclk(sclk_w[1]), .dac_din(din_w[1]),
        .busy(busy_w[1]), .overrun(ovr_w[1])
    );

    audio_output_task #(.SAMPLE_DIV(40)) u_dut_c (
        .clock(clock), .reset(rst[2]), .enable(en[2]), .audio_output_number(lvl[2]),
        .dac_sync(sync_w[2]), .dac_sclk(sclk_w[2]), .dac_din(din_w[2]),
        .busy(busy_w[2]), .overrun(ovr_w[2])
    );

    typedef struct {
        logic [3:0]  level;
        logic        enable;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for sync to fall, then collects din at every sclk falling edge until sync rises.
    task automatic get_frame(input int idx, input int chg, output logic [15:0] w,
                             output int low, output int waited);
        logic prev;
        int   nb;
        w = '0;
        low = 0;
        waited = 0;
        nb = 0;
        while (sync_w[idx] !== 1'b0 && waited < 12000) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (sync_w[idx] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout dut%0d: no sync fall after %0d cycles", idx, waited);
            return;
        end
        prev = sclk_w[idx];
        low = 1;
        while (low < 200) begin
            @(posedge clock);
            #1;
            if (sync_w[idx] !== 1'b0) break;
            low++;
            if (prev === 1'b1 && sclk_w[idx] === 1'b0) begin
                w = {w[14:0], din_w[idx]};
                nb++;
                if (nb == 7 && chg >= 0) lvl[idx] = 4'(chg);
            end
            prev = sclk_w[idx];
        end
    endtask

    int c_low = 0;
    int c_frames = 0;

    always @(posedge clock) begin
        #1;
        if (rst[2] === 1'b0) begin
            if (sync_w[2] === 1'b0) begin
                c_low++;
            end else begin
                if (c_low > 0 && c_frames < 8) begin
                    c_frames++;
                    check("c_frame_len", c_low, 64);
                    check("c_overrun_sticky", ovr_w[2], 1);
                end
                c_low = 0;
            end
        end
    end

    initial begin
        logic [15:0] w;
        int low, waited, n;

        for (int i = 0; i < 10; i++) tbl[i] = '{4'd9, 1'b1, 16'h00F8};
        tbl[10] = '{4'd9,  1'b1, 16'h0F08};
        tbl[11] = '{4'd12, 1'b1, 16'h0F08};
        tbl[12] = '{4'd15, 1'b1, 16'h0F08};
        tbl[13] = '{4'd0,  1'b1, 16'h0800};
        tbl[14] = '{4'd1,  1'b1, 16'h08C8};
        tbl[15] = '{4'd9,  1'b0, 16'h0800};
        tbl[16] = '{4'd9,  1'b0, 16'h0800};
        tbl[17] = '{4'd9,  1'b0, 16'h0800};
        tbl[18] = '{4'd9,  1'b1, 16'h00F8};
        tbl[19] = '{4'd5,  1'b1, 16'h0418};
        tbl[20] = '{4'd2,  1'b1, 16'h0670};

        rst = 3'b111;
        en = 3'b111;
        for (int i = 0; i < 3; i++) lvl[i] = 4'd9;
        repeat (3) @(negedge clock);

        check("rst_sync", sync_w[0], 1);
        check("rst_sclk", sclk_w[0], 1);
        check("rst_din", din_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_overrun", ovr_w[0], 0);

        rst[1] = 1'b0;
        rst[2] = 1'b0;
        for (int i = 0; i < 21; i++) begin
            lvl[1] = tbl[i].level;
            en[1] = tbl[i].enable;
            get_frame(1, -1, w, low, waited);
            if (i == 0) check("b_first_tick", waited, 100);
            check($sformatf("b_word[%0d]", i), w, tbl[i].exp);
            check($sformatf("b_low[%0d]", i), low, 64);
        end

        lvl[1] = 4'd9;
        en[1] = 1'b1;
        get_frame(1, 0, w, low, waited);
        check("b_midframe_level", w, 16'h00F8);
        get_frame(1, -1, w, low, waited);
        check("b_after_level_change", w, 16'h0800);
        check("b_overrun", ovr_w[1], 0);

        @(negedge clock);
        rst[0] = 1'b0;
        get_frame(0, -1, w, low, waited);
        check("a_first_tick", waited, 5000);
        check("a_first_word", w, 16'h00F8);
        check("a_first_low", low, 64);

        n = 0;
        while (sync_w[0] !== 1'b0 && n < 6000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("a_second_frame_start", sync_w[0], 0);
        repeat (31) @(posedge clock);
        #3;
        check("a_pre_rst_sync", sync_w[0], 0);
        check("a_pre_rst_sclk", sclk_w[0], 0);
        rst[0] = 1'b1;
        #1;
        check("a_async_sync", sync_w[0], 1);
        check("a_async_sclk", sclk_w[0], 1);
        check("a_async_din", din_w[0], 0);
        check("a_async_busy", busy_w[0], 0);
        @(negedge clock);
        rst[0] = 1'b0;
        get_frame(0, -1, w, low, waited);
        check("a_post_rst_tick", waited, 5000);
        check("a_post_rst_word", w, 16'h00F8);
        check("a_post_rst_low", low, 64);
        check("a_overrun", ovr_w[0], 0);

        check("c_overrun", ovr_w[2], 1);
        check("c_frames_seen", c_frames, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
